pipe4_fwd_core: RTL and testbench
=================================

# pipe4_fwd_core

Parametrised four-stage integer pipeline (fetch, decode/register-read, execute, write-back) that succeeds the three-stage lab datapath. Adds configurable data width and register count, a valid bit per stage, a pipeline-wide stall, full operand forwarding so back-to-back dependent instructions need no bubbles, and an extended ALU. Sits at the top of the lab datapath, fed by the instruction source, driving the result bus.

## Interface
- DATA_W, 32: datapath and register width; min 8, max 32.
- NREG, 32: register count, power of two, 2..32; REG_AW = clog2(NREG).
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low; clears all state.
- InstrIn  in  32  instruction word.
- InstrValid  in  1  InstrIn is a real instruction this cycle.
- Stall  in  1  freeze every stage; InstrIn ignored.
- ALUOut  out  DATA_W  registered execute result.
- ALUOutValid  out  1  ALUOut belongs to a valid instruction.
- WriteSelOut  out  5  destination register of ALUOut.

## Operation
- Encoding: [31:30] type (00 NOP, 01 R, 10 I, 11 NOP); [29:27] ALUOp; [26:22] rd; [21:17] rs; [16:12] rt (R); [15:0] imm, sign-extended/truncated to DATA_W (I). Register fields use low REG_AW bits.
- ALUOp: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT signed (1/0), 110 SLL A by B[clog2(DATA_W)-1:0], 111 PASS B. A = rs operand; B = rt operand (R) or imm (I).
- Arithmetic modulo 2^DATA_W; overflow discarded, no flags.
- NOP or InstrValid=0 enters as bubble (valid=0); bubbles never write registers and give ALUOutValid=0.
- Register 0 reads 0; writes to rd=0 discarded; ALUOutValid still 1 for them.
- Write-back: when ALUOutValid=1 and Stall=0, register WriteSelOut <= ALUOut at next edge.
- Forwarding for each decode operand, highest priority first: rs/rt = 0 → 0; match valid execute-stage rd≠0 → comb ALU result; match WriteSelOut with ALUOutValid, rd≠0 → ALUOut; else register file.
- Stall=1: all stage registers, outputs, and register file hold; no write occurs; results re-present unchanged.

## Timing
- Instruction accepted at edge k (InstrValid=1, Stall=0) → in S1 after k, decoded and latched to S2 at k+1, ALUOut/ALUOutValid/WriteSelOut valid after k+2, register written at k+3. Latency 3 edges, throughput 1/cycle.
- Dependent instruction accepted at k+1 or k+2 receives the forwarded value; no bubble inserted.
- Stall cycles add 1:1 latency.
- Reset asserted (any time, async): ALUOut=0, ALUOutValid=0, WriteSelOut=0, all stage valids 0, all registers 0; in-flight instructions discarded. First accept at the first rising edge after release.

## Structure
- Package pipe4_pkg: type codes, ALUOp constants, field bit positions, instruction-field struct/typedefs.
- Sub-modules: pipe4_alu (combinational, DATA_W-parametrised) and pipe4_regfile (NREG×DATA_W, one write port, two async read ports, reg 0 constant).
- Top holds stage registers, valid bits, forwarding muxes, stall gating.

## Test plan
- Reset, then I-type ADD r1 = r0 + 5 → ALUOut=5, WriteSelOut=1, ALUOutValid=1 exactly 3 edges after accept.
- Back-to-back: r1=r0+7; r2=r1+r1 (R ADD); r3=r2 SUB r1 → ALUOut 7, 14, 7 on consecutive cycles, no bubbles.
- Write r0 = r0+9, then r4 = r0+1 → first ALUOut=9, second ALUOut=1 (r0 stays zero).
- Stall held 3 cycles mid-stream of r5=r0+3, r6=r5+r5 → ALUOut frozen during stall, resumes 3, 6, total latency +3.
- DATA_W=8: r1=r0+0x7F; r2=r1+r1; r3 = r2 SLT r0 → 0x7F, 0xFE, 1.
- Reset asserted while three instructions in flight → outputs 0 immediately; later read of r1 via PASS B (rt=r1) yields 0.

Source files
------------

// File: rtl/pipe4_pkg.sv
// pipe4_pkg: shared definitions for the four-stage forwarding pipeline.
//   - instruction type codes and ALU operation codes
//   - instruction field bit positions
//   - decoded instruction-field struct and a decode helper
package pipe4_pkg;

  // Instruction class held in bits [31:30]; both NOP encodings become bubbles.
  typedef enum logic [1:0] {
    TYPE_NOP  = 2'b00,
    TYPE_R    = 2'b01,
    TYPE_I    = 2'b10,
    TYPE_NOP3 = 2'b11
  } instrType_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SLT   = 3'b101,
    OP_SLL   = 3'b110,
    OP_PASSB = 3'b111
  } aluOp_t;

  // Field positions (MSB, LSB) within the 32-bit instruction word.
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;
  localparam int OP_MSB   = 29;
  localparam int OP_LSB   = 27;
  localparam int RD_MSB   = 26;
  localparam int RD_LSB   = 22;
  localparam int RS_MSB   = 21;
  localparam int RS_LSB   = 17;
  localparam int RT_MSB   = 16;
  localparam int RT_LSB   = 12;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // rt and imm overlap in the encoding, so they are unpacked separately here.
  typedef struct packed {
    instrType_t  iType;
    aluOp_t      op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } instrFields_t;

  function automatic instrFields_t decodeInstr(input logic [31:0] instr);
    instrFields_t f;
    f.iType = instrType_t'(instr[TYPE_MSB:TYPE_LSB]);
    f.op    = aluOp_t'(instr[OP_MSB:OP_LSB]);
    f.rd    = instr[RD_MSB:RD_LSB];
    f.rs    = instr[RS_MSB:RS_LSB];
    f.rt    = instr[RT_MSB:RT_LSB];
    f.imm   = instr[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  function automatic logic isRealInstr(input instrType_t t);
    return (t == TYPE_R) || (t == TYPE_I);
  endfunction

endpackage

// File: rtl/pipe4_alu.sv
// pipe4_alu: combinational ALU of the execute stage.
// Ports:
//   op     in  aluOp_t  operation select
//   a      in  DATA_W   first operand (rs)
//   b      in  DATA_W   second operand (rt or immediate)
//   result out DATA_W   result, modulo 2^DATA_W, no flags
module pipe4_alu
  import pipe4_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  aluOp_t              op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   result
);

  // Shift amount uses only the low clog2(DATA_W) bits of B.
  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [SH_W-1:0] shAmt;
  assign shAmt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SLT:   result = DATA_W'($signed(a) < $signed(b));
      OP_SLL:   result = a << shAmt;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/pipe4_regfile.sv
// pipe4_regfile: NREG x DATA_W register file, one write port, two
// asynchronous read ports. Register 0 always reads zero and ignores writes.
// Ports:
//   Clk, Reset          clock, asynchronous active-low reset (clears all)
//   wrEn/wrAddr/wrData  write port, applied at the rising edge
//   rdAddrA/rdDataA     read port A (combinational)
//   rdAddrB/rdDataB     read port B (combinational)
module pipe4_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wrEn,
  input  logic [REG_AW-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [REG_AW-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [REG_AW-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataB
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn && (wrAddr != '0)) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = (rdAddrA == '0) ? '0 : regs[rdAddrA];
  assign rdDataB = (rdAddrB == '0) ? '0 : regs[rdAddrB];

endmodule

// File: rtl/pipe4_fwd_core.sv
// pipe4_fwd_core: four-stage integer pipeline (fetch, decode/register-read,
// execute, write-back) with full operand forwarding and a global stall.
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous active-low reset, clears all state
//   InstrIn      in   32-bit instruction word
//   InstrValid   in   InstrIn carries a real instruction this cycle
//   Stall        in   freeze every stage and the register file
//   ALUOut       out  registered execute result
//   ALUOutValid  out  ALUOut belongs to a valid instruction
//   WriteSelOut  out  destination register of ALUOut
//
// Flow control: an instruction is accepted at a rising edge where
// InstrValid=1 and Stall=0; there is no back-pressure other than Stall, and
// while Stall=1 InstrIn/InstrValid are ignored and every register (including
// the outputs and the register file) holds. ALUOut/WriteSelOut are
// meaningful only while ALUOutValid=1, and the result is retired into the
// register file at the first edge where ALUOutValid=1 and Stall=0.
module pipe4_fwd_core
  import pipe4_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       InstrIn,
  input  logic              InstrValid,
  input  logic              Stall,
  output logic [DATA_W-1:0] ALUOut,
  output logic              ALUOutValid,
  output logic [4:0]        WriteSelOut
);

  localparam int REG_AW = $clog2(NREG);

  // Stage 1: fetched instruction.
  logic [31:0]       s1Instr;
  logic              s1Valid;

  // Stage 2: decoded operands awaiting execute.
  logic              s2Valid;
  aluOp_t            s2Op;
  logic [REG_AW-1:0] s2Rd;
  logic [DATA_W-1:0] s2A;
  logic [DATA_W-1:0] s2B;

  // Write-back stage destination (ALUOut/ALUOutValid are the other fields).
  logic [REG_AW-1:0] wbRd;

  instrFields_t      dec;
  logic [REG_AW-1:0] rsIdx;
  logic [REG_AW-1:0] rtIdx;
  logic [REG_AW-1:0] rdIdx;
  logic [DATA_W-1:0] immExt;
  logic [DATA_W-1:0] rfA;
  logic [DATA_W-1:0] rfB;
  logic [DATA_W-1:0] fwdA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluResult;
  logic              rfWrEn;

  // ---------------------------------------------------------------- decode
  assign dec   = decodeInstr(s1Instr);
  assign rsIdx = dec.rs[REG_AW-1:0];
  assign rtIdx = dec.rt[REG_AW-1:0];
  assign rdIdx = dec.rd[REG_AW-1:0];

  // Immediate is sign-extended when the datapath is wider than 16 bits and
  // simply truncated otherwise.
  generate
    if (DATA_W > 16) begin : gImmSext
      assign immExt = {{(DATA_W-16){dec.imm[15]}}, dec.imm};
    end else begin : gImmTrunc
      assign immExt = dec.imm[DATA_W-1:0];
    end
  endgenerate

  // Forwarding. The execute stage is younger than write-back, so it wins.
  // A nonzero source index implies a nonzero destination on a match, which
  // keeps writes to register 0 from ever being forwarded.
  always_comb begin
    fwdA = rfA;
    if (rsIdx == '0) begin
      fwdA = '0;
    end else if (s2Valid && (s2Rd == rsIdx)) begin
      fwdA = aluResult;
    end else if (ALUOutValid && (wbRd == rsIdx)) begin
      fwdA = ALUOut;
    end
  end

  always_comb begin
    fwdB = rfB;
    if (rtIdx == '0) begin
      fwdB = '0;
    end else if (s2Valid && (s2Rd == rtIdx)) begin
      fwdB = aluResult;
    end else if (ALUOutValid && (wbRd == rtIdx)) begin
      fwdB = ALUOut;
    end
  end

  assign opB = (dec.iType == TYPE_R) ? fwdB : immExt;

  // ---------------------------------------------------------------- execute
  pipe4_alu #(
    .DATA_W (DATA_W)
  ) uAlu (
    .op     (s2Op),
    .a      (s2A),
    .b      (s2B),
    .result (aluResult)
  );

  // ---------------------------------------------------------------- registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1Instr     <= '0;
      s1Valid     <= 1'b0;
      s2Valid     <= 1'b0;
      s2Op        <= OP_ADD;
      s2Rd        <= '0;
      s2A         <= '0;
      s2B         <= '0;
      ALUOut      <= '0;
      ALUOutValid <= 1'b0;
      wbRd        <= '0;
    end else if (!Stall) begin
      s1Instr     <= InstrIn;
      s1Valid     <= InstrValid && isRealInstr(instrType_t'(InstrIn[TYPE_MSB:TYPE_LSB]));
      s2Valid     <= s1Valid;
      s2Op        <= dec.op;
      s2Rd        <= rdIdx;
      s2A         <= fwdA;
      s2B         <= opB;
      // Bubbles leave zeros behind so the outputs never show stale data.
      ALUOut      <= s2Valid ? aluResult : '0;
      ALUOutValid <= s2Valid;
      wbRd        <= s2Valid ? s2Rd : '0;
    end
  end

  assign WriteSelOut = 5'(wbRd);

  // ---------------------------------------------------------------- write-back
  assign rfWrEn = ALUOutValid && !Stall;

  pipe4_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) uRegfile (
    .Clk     (Clk),
    .Reset   (Reset),
    .wrEn    (rfWrEn),
    .wrAddr  (wbRd),
    .wrData  (ALUOut),
    .rdAddrA (rsIdx),
    .rdDataA (rfA),
    .rdAddrB (rtIdx),
    .rdDataB (rfB)
  );

endmodule

// File: tb/tb_pipe4_fwd_core.sv
// Bench for pipe4_fwd_core: a 32-bit/32-register instance and an
// 8-bit/8-register instance sharing clock and reset.
module tb_pipe4_fwd_core;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3;
  localparam logic [2:0] XOR = 3'd4, SLT = 3'd5, SLL = 3'd6, PASSB = 3'd7;

  logic        Clk;
  logic        Reset;
  logic [31:0] InstrIn;
  logic        InstrValid;
  logic        Stall;
  logic [31:0] ALUOut;
  logic        ALUOutValid;
  logic [4:0]  WriteSelOut;

  logic [31:0] instr8;
  logic        valid8;
  logic        stall8;
  logic [7:0]  aluOut8;
  logic        aluOutValid8;
  logic [4:0]  writeSel8;

  int nChecks = 0;
  int nFails  = 0;

  pipe4_fwd_core #(.DATA_W(32), .NREG(32)) dut (
    .Clk (Clk), .Reset (Reset), .InstrIn (InstrIn), .InstrValid (InstrValid),
    .Stall (Stall), .ALUOut (ALUOut), .ALUOutValid (ALUOutValid), .WriteSelOut (WriteSelOut)
  );

  pipe4_fwd_core #(.DATA_W(8), .NREG(8)) dut8 (
    .Clk (Clk), .Reset (Reset), .InstrIn (instr8), .InstrValid (valid8),
    .Stall (stall8), .ALUOut (aluOut8), .ALUOutValid (aluOutValid8), .WriteSelOut (writeSel8)
  );

  // ---------------------------------------------------------------- clock/reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- encoders
  function automatic logic [31:0] encI(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {2'b10, op, rd, rs, 1'b0, imm};
  endfunction

  function automatic logic [31:0] encR(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {2'b01, op, rd, rs, rt, 12'd0};
  endfunction

  // ---------------------------------------------------------------- drivers
  // Inputs change 1 time unit after a rising edge; outputs are looked at then.
  task automatic cycle(input logic [31:0] instr, input logic valid, input logic stall);
    InstrIn    = instr;
    InstrValid = valid;
    Stall      = stall;
    @(posedge Clk);
    #1;
  endtask

  task automatic cycle8(input logic [31:0] instr, input logic valid);
    instr8 = instr;
    valid8 = valid;
    @(posedge Clk);
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    Reset = 1'b0; InstrIn = '0; InstrValid = 1'b0; Stall = 1'b0;
    instr8 = '0; valid8 = 1'b0; stall8 = 1'b0;
    #23;
    nChecks++; if (ALUOut !== 32'd0) begin nFails++; $display("FAIL reset_aluout: got %h want %h", ALUOut, 32'd0); end
    nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b want 0", ALUOutValid); end
    nChecks++; if (WriteSelOut !== 5'd0) begin nFails++; $display("FAIL reset_sel: got %0d want 0", WriteSelOut); end
    nChecks++; if (aluOutValid8 !== 1'b0) begin nFails++; $display("FAIL reset_valid8: got %b want 0", aluOutValid8); end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_single_add;
    cycle(encI(ADD, 5'd1, 5'd0, 16'd5), 1'b1, 1'b0);
    nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL single_early1: valid got %b want 0", ALUOutValid); end
    cycle('0, 1'b0, 1'b0);
    nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL single_early2: valid got %b want 0", ALUOutValid); end
    cycle('0, 1'b0, 1'b0);
    nChecks++; if (ALUOutValid !== 1'b1) begin nFails++; $display("FAIL single_valid: got %b want 1", ALUOutValid); end
    nChecks++; if (ALUOut !== 32'd5) begin nFails++; $display("FAIL single_out: got %h want %h", ALUOut, 32'd5); end
    nChecks++; if (WriteSelOut !== 5'd1) begin nFails++; $display("FAIL single_sel: got %0d want 1", WriteSelOut); end
    cycle('0, 1'b0, 1'b0);
    nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL single_after: valid got %b want 0", ALUOutValid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins  [3];
    logic [31:0] expv [3];
    logic [4:0]  exps [3];
    ins  = '{encI(ADD, 5'd1, 5'd0, 16'd7), encR(ADD, 5'd2, 5'd1, 5'd1), encR(SUB, 5'd3, 5'd2, 5'd1)};
    expv = '{32'd7, 32'd14, 32'd7};
    exps = '{5'd1, 5'd2, 5'd3};
    for (int i = 0; i < 6; i++) begin
      cycle((i < 3) ? ins[i] : 32'd0, i < 3, 1'b0);
      if (i >= 2 && i < 5) begin
        nChecks++; if (ALUOutValid !== 1'b1) begin nFails++; $display("FAIL b2b_valid[%0d]: got %b want 1", i-2, ALUOutValid); end
        nChecks++; if (ALUOut !== expv[i-2]) begin nFails++; $display("FAIL b2b_out[%0d]: got %h want %h", i-2, ALUOut, expv[i-2]); end
        nChecks++; if (WriteSelOut !== exps[i-2]) begin nFails++; $display("FAIL b2b_sel[%0d]: got %0d want %0d", i-2, WriteSelOut, exps[i-2]); end
      end else if (i == 5) begin
        nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL b2b_tail: valid got %b want 0", ALUOutValid); end
      end
    end
  endtask

  task automatic test_r0_write;
    logic [31:0] ins  [2];
    logic [31:0] expv [2];
    logic [4:0]  exps [2];
    ins  = '{encI(ADD, 5'd0, 5'd0, 16'd9), encI(ADD, 5'd4, 5'd0, 16'd1)};
    expv = '{32'd9, 32'd1};
    exps = '{5'd0, 5'd4};
    for (int i = 0; i < 4; i++) begin
      cycle((i < 2) ? ins[i] : 32'd0, i < 2, 1'b0);
      if (i >= 2) begin
        nChecks++; if (ALUOutValid !== 1'b1) begin nFails++; $display("FAIL r0_valid[%0d]: got %b want 1", i-2, ALUOutValid); end
        nChecks++; if (ALUOut !== expv[i-2]) begin nFails++; $display("FAIL r0_out[%0d]: got %h want %h", i-2, ALUOut, expv[i-2]); end
        nChecks++; if (WriteSelOut !== exps[i-2]) begin nFails++; $display("FAIL r0_sel[%0d]: got %0d want %0d", i-2, WriteSelOut, exps[i-2]); end
      end
    end
  endtask

  task automatic test_stall;
    cycle(encI(ADD, 5'd5, 5'd0, 16'd3), 1'b1, 1'b0);
    cycle(encR(ADD, 5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b0);
    nChecks++; if (ALUOut !== 32'd3) begin nFails++; $display("FAIL stall_pre_out: got %h want %h", ALUOut, 32'd3); end
    // A valid instruction is offered while stalled; it must be ignored.
    for (int i = 0; i < 3; i++) begin
      cycle(encI(ADD, 5'd7, 5'd0, 16'h0055), 1'b1, 1'b1);
      nChecks++; if (ALUOutValid !== 1'b1) begin nFails++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", i, ALUOutValid); end
      nChecks++; if (ALUOut !== 32'd3) begin nFails++; $display("FAIL stall_hold_out[%0d]: got %h want %h", i, ALUOut, 32'd3); end
      nChecks++; if (WriteSelOut !== 5'd5) begin nFails++; $display("FAIL stall_hold_sel[%0d]: got %0d want 5", i, WriteSelOut); end
    end
    cycle('0, 1'b0, 1'b0);
    nChecks++; if (ALUOut !== 32'd6) begin nFails++; $display("FAIL stall_resume_out: got %h want %h", ALUOut, 32'd6); end
    nChecks++; if (WriteSelOut !== 5'd6) begin nFails++; $display("FAIL stall_resume_sel: got %0d want 6", WriteSelOut); end
    cycle('0, 1'b0, 1'b0);
    nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL stall_ignored_in: valid got %b want 0", ALUOutValid); end
    cycle('0, 1'b0, 1'b0);
  endtask

  // Reads registers back through PASS B once all writes have retired.
  task automatic test_readback;
    logic [4:0]  rts  [6];
    logic [31:0] expv [6];
    rts  = '{5'd5, 5'd6, 5'd0, 5'd4, 5'd7, 5'd3};
    expv = '{32'd3, 32'd6, 32'd0, 32'd1, 32'd0, 32'd7};
    for (int i = 0; i < 8; i++) begin
      cycle((i < 6) ? encR(PASSB, 5'(10 + i), 5'd0, rts[i]) : 32'd0, i < 6, 1'b0);
      if (i >= 2) begin
        nChecks++; if (ALUOut !== expv[i-2]) begin nFails++; $display("FAIL readback_r%0d: got %h want %h", rts[i-2], ALUOut, expv[i-2]); end
        nChecks++; if (WriteSelOut !== 5'(8 + i)) begin nFails++; $display("FAIL readback_sel[%0d]: got %0d want %0d", i-2, WriteSelOut, 8 + i); end
      end
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] ins [12];
    logic [31:0] expQ [$];
    logic [4:0]  selQ [$];
    logic [31:0] e;
    logic [4:0]  s;
    ins = '{encI(AND, 5'd11, 5'd2, 16'h0006),
            encI(OR,  5'd12, 5'd2, 16'h0001),
            encI(XOR, 5'd13, 5'd2, 16'h000F),
            encI(SUB, 5'd14, 5'd1, 16'd10),
            encI(ADD, 5'd8,  5'd0, 16'hFFFF),
            encR(SLT, 5'd9,  5'd8, 5'd1),
            encR(SLT, 5'd15, 5'd1, 5'd8),
            encI(SLL, 5'd16, 5'd1, 16'd4),
            encI(SLL, 5'd17, 5'd1, 16'h0021),
            encI(PASSB, 5'd18, 5'd0, 16'h8000),
            encI(ADD, 5'd19, 5'd8, 16'd2),
            encI(SLT, 5'd20, 5'd14, 16'hFFFE)};
    expQ = '{32'd6, 32'd15, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
             32'd0, 32'h70, 32'd14, 32'hFFFF_8000, 32'd1, 32'd1};
    selQ = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd8, 5'd9, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
    for (int c = 0; c < 20; c++) begin
      cycle((c < 12) ? ins[c] : 32'd0, c < 12, 1'b0);
      if (ALUOutValid === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++; nFails++; $display("FAIL alu_extra: unexpected result %h at cycle %0d", ALUOut, c);
        end else begin
          e = expQ.pop_front();
          s = selQ.pop_front();
          nChecks++; if (ALUOut !== e) begin nFails++; $display("FAIL alu_out_r%0d: got %h want %h", s, ALUOut, e); end
          nChecks++; if (WriteSelOut !== s) begin nFails++; $display("FAIL alu_sel: got %0d want %0d", WriteSelOut, s); end
        end
      end
    end
    nChecks++; if (expQ.size() != 0) begin nFails++; $display("FAIL alu_missing: %0d results outstanding, want 0", expQ.size()); end
  endtask

  task automatic test_bubbles;
    cycle(encI(ADD, 5'd21, 5'd0, 16'd5), 1'b0, 1'b0);
    cycle({2'b00, 3'd0, 5'd22, 22'd5}, 1'b1, 1'b0);
    cycle({2'b11, 3'd0, 5'd23, 22'd5}, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL bubble_valid[%0d]: got %b want 0", i, ALUOutValid); end
      cycle('0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_width8;
    logic [31:0] ins  [5];
    logic [7:0]  expv [5];
    logic [4:0]  exps [5];
    ins  = '{encI(ADD, 5'd1, 5'd0, 16'h007F), encR(ADD, 5'd2, 5'd1, 5'd1),
             encR(SLT, 5'd3, 5'd2, 5'd0), encI(ADD, 5'd12, 5'd0, 16'h1234),
             encR(PASSB, 5'd13, 5'd0, 5'd9)};
    expv = '{8'h7F, 8'hFE, 8'h01, 8'h34, 8'h7F};
    exps = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    for (int i = 0; i < 8; i++) begin
      cycle8((i < 5) ? ins[i] : 32'd0, i < 5);
      if (i >= 2 && i < 7) begin
        nChecks++; if (aluOutValid8 !== 1'b1) begin nFails++; $display("FAIL w8_valid[%0d]: got %b want 1", i-2, aluOutValid8); end
        nChecks++; if (aluOut8 !== expv[i-2]) begin nFails++; $display("FAIL w8_out[%0d]: got %h want %h", i-2, aluOut8, expv[i-2]); end
        nChecks++; if (writeSel8 !== exps[i-2]) begin nFails++; $display("FAIL w8_sel[%0d]: got %0d want %0d", i-2, writeSel8, exps[i-2]); end
      end else if (i == 7) begin
        nChecks++; if (aluOutValid8 !== 1'b0) begin nFails++; $display("FAIL w8_tail: valid got %b want 0", aluOutValid8); end
      end
    end
  endtask

  task automatic test_reset_inflight;
    logic [4:0] rts [3];
    rts = '{5'd1, 5'd2, 5'd5};
    cycle(encI(ADD, 5'd1, 5'd0, 16'h0011), 1'b1, 1'b0);
    cycle(encR(ADD, 5'd2, 5'd1, 5'd1), 1'b1, 1'b0);
    cycle(encR(ADD, 5'd3, 5'd2, 5'd2), 1'b1, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    nChecks++; if (ALUOut !== 32'd0) begin nFails++; $display("FAIL rst_fly_out: got %h want %h", ALUOut, 32'd0); end
    nChecks++; if (ALUOutValid !== 1'b0) begin nFails++; $display("FAIL rst_fly_valid: got %b want 0", ALUOutValid); end
    nChecks++; if (WriteSelOut !== 5'd0) begin nFails++; $display("FAIL rst_fly_sel: got %0d want 0", WriteSelOut); end
    cycle('0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle((i < 3) ? encR(PASSB, 5'(24 + i), 5'd0, rts[i]) : 32'd0, i < 3, 1'b0);
      if (i >= 2) begin
        nChecks++; if (ALUOutValid !== 1'b1) begin nFails++; $display("FAIL rst_read_valid[%0d]: got %b want 1", i-2, ALUOutValid); end
        nChecks++; if (ALUOut !== 32'd0) begin nFails++; $display("FAIL rst_read_r%0d: got %h want %h", rts[i-2], ALUOut, 32'd0); end
        nChecks++; if (WriteSelOut !== 5'(22 + i)) begin nFails++; $display("FAIL rst_read_sel[%0d]: got %0d want %0d", i-2, WriteSelOut, 22 + i); end
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset;
    test_single_add;
    test_back_to_back;
    test_r0_write;
    test_stall;
    test_readback;
    test_alu_ops;
    test_bubbles;
    test_width8;
    test_reset_inflight;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
